// File: rtl/audio_pkg.sv
// Shared audio types and constants for the AudVid audio output path.
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int UNDERRUN_CNT_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

    typedef struct packed {
        logic [SAMPLE_WIDTH_DEF-1:0] left;
        logic [SAMPLE_WIDTH_DEF-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: buffers stereo frames and shifts them MSB-first to the DAC pins.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int CLK_DIV      = 35,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic                               enable,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic [SAMPLE_WIDTH-1:0]            sample_left,
    input  logic [SAMPLE_WIDTH-1:0]            sample_right,
    output logic                               DAC_I2S_CLK,
    output logic                               DAC_I2S_WS,
    output logic                               DAC_I2S_DATA,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               underrun,
    output logic [UNDERRUN_CNT_W-1:0]          underrun_count
);

    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam int BW = $clog2(FW);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    i2s_state_t              r_state;
    i2s_state_t              w_state_next;
    logic [DW-1:0]           r_div;
    logic [BW-1:0]           r_bit;
    logic [FW-1:0]           r_shift;
    logic                    r_bclk;
    logic                    r_ws;
    logic                    r_data;
    logic                    r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_underrun_count;

    logic                    w_div_tc;
    logic                    w_fall;
    logic [BW-1:0]           w_bit_next;
    logic                    w_load;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [FW-1:0]           w_fifo_rdata;
    logic [FW-1:0]           w_frame;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_push  (sample_valid && sample_ready),
        .i_wdata ({sample_left, sample_right}),
        .i_pop   (w_load),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign w_div_tc   = (r_div == DW'(CLK_DIV - 1));
    assign w_fall     = (r_state == RUN) && enable && w_div_tc && r_bclk;
    assign w_bit_next = (r_bit == BW'(FW - 1)) ? '0 : r_bit + 1'b1;
    assign w_load     = ((r_state == IDLE) && enable) || (w_fall && (w_bit_next == '0));
    assign w_frame    = w_fifo_empty ? '0 : w_fifo_rdata;

    // NOTE: the next state gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_div            <= '0;
            r_bit            <= '0;
            r_shift          <= '0;
            r_bclk           <= 1'b0;
            r_ws             <= 1'b0;
            r_data           <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load && w_fifo_empty) begin
                r_underrun <= 1'b1;
                if (r_underrun_count != '1) r_underrun_count <= r_underrun_count + 1'b1;
            end

            if ((r_state == IDLE) || !enable) begin
                // Entering RUN starts from the same zeroed pins/counters as leaving it.
                r_div  <= '0;
                r_bit  <= '0;
                r_bclk <= 1'b0;
                r_ws   <= 1'b0;
                r_data <= 1'b0;
            end else if (w_div_tc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
                if (r_bclk) begin
                    r_bit <= w_bit_next;
                    r_ws  <= (w_bit_next >= BW'(SAMPLE_WIDTH - 1)) && (w_bit_next <= BW'(FW - 2));
                end
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_load) begin
                r_data  <= w_frame[FW-1];
                r_shift <= {w_frame[FW-2:0], 1'b0};
            end else if (w_fall) begin
                r_data  <= r_shift[FW-1];
                r_shift <= {r_shift[FW-2:0], 1'b0};
            end
        end
    end

    assign sample_ready   = !w_fifo_full;
    assign DAC_I2S_CLK    = r_bclk;
    assign DAC_I2S_WS     = r_ws;
    assign DAC_I2S_DATA   = r_data;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: frame-level reference model checked every cycle plus directed literal checks.
module tb_i2s_dac_tx;
    import audio_pkg::*;

    localparam int W      = 16;
    localparam int CDIV   = 2;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 4 * W * CDIV;

    logic        CLK;
    logic        Reset;
    logic        enable;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        DAC_I2S_CLK;
    logic        DAC_I2S_WS;
    logic        DAC_I2S_DATA;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_count;

    i2s_dac_tx #(
        .SAMPLE_WIDTH (W),
        .CLK_DIV      (CDIV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .DAC_I2S_CLK    (DAC_I2S_CLK),
        .DAC_I2S_WS     (DAC_I2S_WS),
        .DAC_I2S_DATA   (DAC_I2S_DATA),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames come out of a queue; pin values follow from the cycle offset in the frame.
    stereo_frame_t mq[$];
    bit            m_ok   = 1'b0;
    bit            m_run  = 1'b0;
    int            m_k    = 0;
    stereo_frame_t m_cur  = '0;
    int            m_ucnt = 0;
    bit            m_upulse = 1'b0;

    always @(posedge CLK) begin
        bit do_push;
        bit do_load;
        if (Reset) begin
            mq.delete();
            m_ok     = 1'b1;
            m_run    = 1'b0;
            m_k      = 0;
            m_cur    = '0;
            m_ucnt   = 0;
            m_upulse = 1'b0;
        end else begin
            do_push  = sample_valid && (mq.size() < DEPTH);
            do_load  = 1'b0;
            m_upulse = 1'b0;
            if (!m_run) begin
                if (enable) begin
                    m_run   = 1'b1;
                    m_k     = 0;
                    do_load = 1'b1;
                end
            end else if (!enable) begin
                m_run = 1'b0;
                m_k   = 0;
            end else begin
                m_k++;
                if (m_k == PERIOD) begin
                    m_k     = 0;
                    do_load = 1'b1;
                end
            end
            if (do_load) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                end else begin
                    m_cur    = '0;
                    m_upulse = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (do_push) mq.push_back('{left: sample_left, right: sample_right});
        end
    end

    always @(negedge CLK) begin
        int  half;
        int  b;
        logic e_bclk, e_ws, e_data;
        if (m_ok) begin
            e_bclk = 1'b0;
            e_ws   = 1'b0;
            e_data = 1'b0;
            if (m_run) begin
                half   = m_k / CDIV;
                b      = half / 2;
                e_bclk = half[0];
                e_data = m_cur[2*W-1-b];
                e_ws   = (b >= W - 1) && (b <= 2*W - 2);
            end
            check("m_bclk",  DAC_I2S_CLK,    e_bclk);
            check("m_ws",    DAC_I2S_WS,     e_ws);
            check("m_data",  DAC_I2S_DATA,   e_data);
            check("m_level", fifo_level,     mq.size());
            check("m_ready", sample_ready,   mq.size() < DEPTH);
            check("m_under", underrun,       m_upulse);
            check("m_ucnt",  underrun_count, m_ucnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        while (!sample_ready && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        check("push_ready", sample_ready, 1);
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        @(negedge CLK);
        sample_valid = 1'b0;
    endtask

    function automatic logic [15:0] stream_l(input int i);
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] stream_r(input int i);
        return 16'(i * 4099 + 7);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap_d;
        logic [31:0] cap_ws;
        int          pulses;
        logic        or_d;
        int          i;
        int          guard;
        logic        acc;

        Reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
        tick(3);
        check("rst_bclk",  DAC_I2S_CLK,    0);
        check("rst_ws",    DAC_I2S_WS,     0);
        check("rst_data",  DAC_I2S_DATA,   0);
        check("rst_level", fifo_level,     0);
        check("rst_ready", sample_ready,   1);
        check("rst_ucnt",  underrun_count, 0);
        Reset = 1'b0;
        tick(1);

        // Single frame A55A/0FF0 sampled on rising BCLK edges.
        push(16'hA55A, 16'h0FF0);
        check("t1_level", fifo_level, 1);
        enable = 1'b1;
        cap_d  = '0;
        cap_ws = '0;
        for (int m = 0; m < PERIOD; m++) begin
            @(negedge CLK);
            if (m == 0) check("t1_pop", fifo_level, 0);
            if (m % 4 == 2) begin
                cap_d  = {cap_d[30:0], DAC_I2S_DATA};
                cap_ws = {cap_ws[30:0], DAC_I2S_WS};
            end
            if (m == PERIOD - 1) enable = 1'b0;
        end
        check("t1_bits", cap_d, 32'hA55A0FF0);
        check("t1_ws",   cap_ws, 32'h0001FFFE);
        tick(1);
        check("t1_idle_bclk", DAC_I2S_CLK, 0);
        check("t1_ucnt",      underrun_count, 0);

        // Underrun frames, then saturation from a preloaded count.
        Reset = 1'b1;
        tick(1);
        Reset  = 1'b0;
        enable = 1'b1;
        pulses = 0;
        or_d   = 1'b0;
        for (int m = 0; m < 3 * PERIOD; m++) begin
            @(negedge CLK);
            pulses += int'(underrun);
            or_d   |= DAC_I2S_DATA;
            if (m % PERIOD == 0) check("t3_ucnt", underrun_count, m / PERIOD + 1);
        end
        check("t3_pulses", pulses, 3);
        check("t3_silent", or_d, 0);
        @(posedge CLK);
        #2;
        force dut.r_underrun_count = 16'hFFFE;
        m_ucnt = 65534;
        #1;
        release dut.r_underrun_count;
        @(negedge CLK);
        tick(PERIOD);
        check("t3_sat1", underrun_count, 16'hFFFF);
        check("t3_pulse_sat", underrun, 1);
        tick(PERIOD);
        check("t3_sat2", underrun_count, 16'hFFFF);
        enable = 1'b0;
        tick(2);

        // FIFO full, blocked fifth frame, then reset mid-frame (Reset beating enable).
        Reset = 1'b1;
        tick(1);
        check("t2_rst_ucnt", underrun_count, 0);
        Reset = 1'b0;
        for (int f = 0; f < 4; f++) push(16'(16'h1111 * (f + 1)), 16'(16'h8000 | f));
        check("t2_full_level", fifo_level, 4);
        check("t2_full_ready", sample_ready, 0);
        sample_valid = 1'b1;
        sample_left  = 16'hDEAD;
        sample_right = 16'hBEEF;
        tick(3);
        check("t2_blocked", fifo_level, 4);
        sample_valid = 1'b0;
        enable = 1'b1;
        tick(1);
        check("t2_first_load", fifo_level, 3);
        check("t2_ready_again", sample_ready, 1);
        tick(40);
        Reset = 1'b1;
        tick(1);
        check("t6_bclk",  DAC_I2S_CLK,    0);
        check("t6_ws",    DAC_I2S_WS,     0);
        check("t6_data",  DAC_I2S_DATA,   0);
        check("t6_level", fifo_level,     0);
        check("t6_ready", sample_ready,   1);
        check("t6_under", underrun,       0);
        tick(1);
        check("t6_reset_wins", DAC_I2S_CLK | DAC_I2S_WS | DAC_I2S_DATA, 0);
        Reset  = 1'b0;
        enable = 1'b0;
        tick(1);

        // Abort a frame at bit 7, then resume with the next queued frame.
        push(16'h1357, 16'h2468);
        push(16'hFEDC, 16'hBA98);
        enable = 1'b1;
        for (int m = 0; m < 30; m++) begin
            @(negedge CLK);
            if (m == 29) enable = 1'b0;
        end
        tick(1);
        check("t5_pins_off", DAC_I2S_CLK | DAC_I2S_WS | DAC_I2S_DATA, 0);
        check("t5_level", fifo_level, 1);
        tick(3);
        enable = 1'b1;
        tick(1);
        check("t5_resume_data", DAC_I2S_DATA, 1);
        check("t5_resume_ws",   DAC_I2S_WS,   0);
        check("t5_resume_lvl",  fifo_level,   0);
        tick(PERIOD - 2);
        enable = 1'b0;
        tick(2);

        // Back-to-back streaming of 100 frames with valid held high.
        i     = 0;
        guard = 0;
        sample_valid = 1'b1;
        sample_left  = stream_l(0);
        sample_right = stream_r(0);
        while (i < 100 && guard < 20000) begin
            acc = sample_ready;
            @(negedge CLK);
            guard++;
            if (acc) begin
                i++;
                if (i == 2) enable = 1'b1;
                sample_left  = stream_l(i);
                sample_right = stream_r(i);
            end
        end
        sample_valid = 1'b0;
        check("t4_sent", i, 100);
        guard = 0;
        while (fifo_level != 0 && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        check("t4_drained", fifo_level, 0);
        tick(10);
        enable = 1'b0;
        tick(2);
        check("t4_no_underrun", underrun_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
